// File: rtl/mux_rr_n_if.sv
// Handshake bundle for mux_rr_n: NCH source channels in, one registered word out.
// slave is the selector's view, master is the sources/consumer view.
interface mux_rr_n_if #(
    parameter  int NBITS = 4,
    parameter  int NCH   = 16,
    localparam int SELW  = $clog2(NCH)
);
    logic [NCH*NBITS-1:0] data_in;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic                 mode;
    logic [SELW-1:0]      selection;
    logic [NBITS-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready;

    modport slave (
        input  data_in, in_valid, mode, selection, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );

    modport master (
        output data_in, in_valid, mode, selection, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/mux_rr_n.sv
// N-channel registered selector, manual or round-robin pick, one-entry output register.
// Optional MUX_N_GRANT_CNT_EN adds a saturating grant counter output (grant_cnt).
module mux_rr_n #(
    parameter  int NBITS = 4,
    parameter  int NCH   = 16,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic        clk,
    input  logic        rst,
`ifdef MUX_N_GRANT_CNT_EN
    output logic [15:0] grant_cnt,
`endif
    mux_rr_n_if.slave   bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                    state_q, state_d;
    logic [NBITS-1:0]          out_data_q, out_data_d;
    logic [SELW-1:0]           out_ch_q, out_ch_d;
    logic [SELW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [SELW-1:0]           cand;
    logic                      cand_found;
    logic                      can_load;
    logic                      grant;
    logic [NCH-1:0]            in_ready;
    logic [NCH-1:0][NBITS-1:0] words;

    assign words = bus.data_in;

    // Round-robin scan starts at rr_ptr and wraps; first valid channel wins.
    always_comb begin : cand_sel
        logic [SELW-1:0] idx;
        idx        = '0;
        cand       = '0;
        cand_found = 1'b0;
        if (!bus.mode) begin
            if (int'(bus.selection) < NCH) begin
                cand       = bus.selection;
                cand_found = 1'b1;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                idx = SELW'((int'(rr_ptr_q) + i) % NCH);
                if (!cand_found && bus.in_valid[idx]) begin
                    cand       = idx;
                    cand_found = 1'b1;
                end
            end
        end
    end

    // Draining and refilling in the same cycle keeps full throughput.
    assign can_load = (state_q == EMPTY) || bus.out_ready;
    assign grant    = !rst && can_load && cand_found && bus.in_valid[cand];

    always_comb begin
        in_ready = '0;
        if (grant) in_ready[cand] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        rr_ptr_d   = rr_ptr_q;
        if (grant) begin
            state_d    = FULL;
            out_data_d = words[cand];
            out_ch_d   = cand;
            if (bus.mode)
                rr_ptr_d = (cand == SELW'(NCH - 1)) ? '0 : cand + SELW'(1);
        end else if (state_q == FULL && bus.out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
            out_ch_q   <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

`ifdef MUX_N_GRANT_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    assign cnt_d = (grant && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign grant_cnt = cnt_q;
`endif
endmodule
